// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the decode-stage pipeline sequencer.
package pipe_ctrl_pkg;

  // Sequencer FSM state encodings
  localparam logic [1:0] PCTRL_IDLE  = 2'd0;
  localparam logic [1:0] PCTRL_DIV   = 2'd1;
  localparam logic [1:0] PCTRL_FLUSH = 2'd2;

  // Load opcode; id uses it to produce id_is_load_i upstream of this block
  localparam logic [6:0] INST_TYPE_I_L = 7'b0000011;

  // x0 is hardwired zero, so address 0 never names a real producer/consumer
  function automatic logic reg_used(input logic [4:0] addr);
    return addr != 5'd0;
  endfunction

endpackage

// File: rtl/pipe_ctrl_scoreboard.sv
// Per-register pending-load scoreboard with two combinational read ports.
module pctrl_scoreboard #(
  parameter int REG_NUM = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_i,
  input  logic [4:0] set_addr_i,
  input  logic       clr_i,
  input  logic [4:0] clr_addr_i,
  input  logic [4:0] rs1_addr_i,
  input  logic [4:0] rs2_addr_i,
  output logic       rs1_busy_o,
  output logic       rs2_busy_o
);

  logic [REG_NUM-1:0] sb_q, sb_d;

  // Next scoreboard: clear on load writeback, then set on load issue so a same-cycle set wins
  always_comb begin
    sb_d = sb_q;
    for (int i = 1; i < REG_NUM; i++) begin
      if (clr_i && (clr_addr_i == 5'(i))) sb_d[i] = 1'b0;
      if (set_i && (set_addr_i == 5'(i))) sb_d[i] = 1'b1;
    end
    sb_d[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk) begin
    if (rst) sb_q <= '0;
    else     sb_q <= sb_d;
  end

  assign rs1_busy_o = sb_q[rs1_addr_i];
  assign rs2_busy_o = sb_q[rs2_addr_i];

endmodule

// File: rtl/pipe_ctrl.sv
// Decode-stage pipeline sequencer: load-use and divide stalls, jump flush and PC redirect.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_NUM      = 32,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        id_valid_i,
  input  logic [4:0]  id_rs1_addr_i,
  input  logic [4:0]  id_rs2_addr_i,
  input  logic [4:0]  id_rd_addr_i,
  input  logic        id_is_load_i,
  input  logic        ex_jump_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        ex_div_start_i,
  input  logic        ex_div_done_i,
  input  logic        wb_load_we_i,
  input  logic [4:0]  wb_rd_addr_i,
  output logic        stall_pc_o,
  output logic        stall_if_id_o,
  output logic        bubble_id_ex_o,
  output logic        flush_o,
  output logic        jump_o,
  output logic [31:0] jump_addr_o
);

  // The jump cycle itself is the first flush cycle, so the counter covers the remainder.
  // With a single flush cycle the FSM never leaves IDLE.
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [1:0] JUMP_NEXT  = (FLUSH_CYCLES > 1) ? PCTRL_FLUSH : PCTRL_IDLE;

  logic [1:0] state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       take_jump, flush, div_stall, load_use, stall;
  logic       rs1_busy, rs2_busy, sb_set;

  pctrl_scoreboard #(.REG_NUM(REG_NUM)) u_sb (
    .clk        (clk),
    .rst        (rst),
    .set_i      (sb_set),
    .set_addr_i (id_rd_addr_i),
    .clr_i      (wb_load_we_i),
    .clr_addr_i (wb_rd_addr_i),
    .rs1_addr_i (id_rs1_addr_i),
    .rs2_addr_i (id_rs2_addr_i),
    .rs1_busy_o (rs1_busy),
    .rs2_busy_o (rs2_busy)
  );

  // Hazard detection and output priority: jump/flush over divide over load-use
  always_comb begin
    take_jump = ~rst & (state_q == PCTRL_IDLE) & ex_jump_i;
    flush     = ~rst & (take_jump | (state_q == PCTRL_FLUSH));
    div_stall = ((state_q == PCTRL_IDLE) & ex_div_start_i | (state_q == PCTRL_DIV))
                & ~ex_div_done_i;
    load_use  = id_valid_i & ((reg_used(id_rs1_addr_i) & rs1_busy) |
                              (reg_used(id_rs2_addr_i) & rs2_busy));
    stall     = ~rst & ~flush & (div_stall | load_use);
    sb_set    = id_valid_i & id_is_load_i & reg_used(id_rd_addr_i) & ~stall & ~flush;
  end

  assign stall_pc_o     = stall;
  assign stall_if_id_o  = stall;
  assign bubble_id_ex_o = stall;
  assign flush_o        = flush;
  assign jump_o         = take_jump;
  assign jump_addr_o    = take_jump ? ex_jump_addr_i : 32'd0;

  // FSM next state; FLUSH exits when the decremented count reaches zero
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      PCTRL_IDLE: begin
        if (ex_jump_i) begin
          state_d = JUMP_NEXT;
          cnt_d   = FLUSH_INIT;
        end else if (ex_div_start_i && !ex_div_done_i) begin
          state_d = PCTRL_DIV;
        end
      end
      PCTRL_DIV: begin
        if (ex_div_done_i) state_d = PCTRL_IDLE;
      end
      PCTRL_FLUSH: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q <= 3'd1) state_d = PCTRL_IDLE;
      end
      default: state_d = PCTRL_IDLE;
    endcase
  end

  // FSM and flush counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PCTRL_IDLE;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed-vector bench for pipe_ctrl (REG_NUM=32, FLUSH_CYCLES=2).
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid_i;
  logic [4:0]  id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
  logic        id_is_load_i;
  logic        ex_jump_i;
  logic [31:0] ex_jump_addr_i;
  logic        ex_div_start_i, ex_div_done_i;
  logic        wb_load_we_i;
  logic [4:0]  wb_rd_addr_i;
  logic        stall_pc_o, stall_if_id_o, bubble_id_ex_o, flush_o, jump_o;
  logic [31:0] jump_addr_o;

  int n_vec = 0;
  int n_err = 0;

  pipe_ctrl #(.REG_NUM(32), .FLUSH_CYCLES(2)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_valid_i     (id_valid_i),
    .id_rs1_addr_i  (id_rs1_addr_i),
    .id_rs2_addr_i  (id_rs2_addr_i),
    .id_rd_addr_i   (id_rd_addr_i),
    .id_is_load_i   (id_is_load_i),
    .ex_jump_i      (ex_jump_i),
    .ex_jump_addr_i (ex_jump_addr_i),
    .ex_div_start_i (ex_div_start_i),
    .ex_div_done_i  (ex_div_done_i),
    .wb_load_we_i   (wb_load_we_i),
    .wb_rd_addr_i   (wb_rd_addr_i),
    .stall_pc_o     (stall_pc_o),
    .stall_if_id_o  (stall_if_id_o),
    .bubble_id_ex_o (bubble_id_ex_o),
    .flush_o        (flush_o),
    .jump_o         (jump_o),
    .jump_addr_o    (jump_addr_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic st, input logic fl,
                         input logic jp, input logic [31:0] ad);
    chk({tag, ".stall_pc"},  32'(stall_pc_o),     32'(st));
    chk({tag, ".stall_ifid"}, 32'(stall_if_id_o), 32'(st));
    chk({tag, ".bubble"},    32'(bubble_id_ex_o), 32'(st));
    chk({tag, ".flush"},     32'(flush_o),        32'(fl));
    chk({tag, ".jump"},      32'(jump_o),         32'(jp));
    chk({tag, ".jaddr"},     jump_addr_o,         ad);
  endtask

  // Advance past the next rising edge and return all inputs to idle
  task automatic next_cyc();
    @(posedge clk);
    #1;
    id_valid_i = 0; id_rs1_addr_i = 0; id_rs2_addr_i = 0; id_rd_addr_i = 0;
    id_is_load_i = 0; ex_jump_i = 0; ex_jump_addr_i = 0;
    ex_div_start_i = 0; ex_div_done_i = 0; wb_load_we_i = 0; wb_rd_addr_i = 0;
  endtask

  task automatic id_load(input logic [4:0] rd);
    id_valid_i = 1; id_is_load_i = 1; id_rd_addr_i = rd;
  endtask

  task automatic id_read(input logic [4:0] rs1, input logic [4:0] rs2);
    id_valid_i = 1; id_rs1_addr_i = rs1; id_rs2_addr_i = rs2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1;
    next_cyc();
    next_cyc();
    #1 chk_out("reset", 0, 0, 0, 32'h0);
    next_cyc();
    rst = 0;
    #1 chk_out("post_reset", 0, 0, 0, 32'h0);

    // load x5, then consumer of x5 stalls until the cycle after writeback
    next_cyc(); id_load(5'd5); id_rs1_addr_i = 5'd1; id_rs2_addr_i = 5'd2;
    #1 chk_out("lu.issue", 0, 0, 0, 32'h0);
    next_cyc(); id_read(5'd5, 5'd0); id_rd_addr_i = 5'd6;
    #1 chk_out("lu.use0", 1, 0, 0, 32'h0);
    next_cyc(); id_read(5'd5, 5'd0); id_rd_addr_i = 5'd6;
    #1 chk_out("lu.use1", 1, 0, 0, 32'h0);
    next_cyc(); id_read(5'd5, 5'd0); id_rd_addr_i = 5'd6; wb_load_we_i = 1; wb_rd_addr_i = 5'd5;
    #1 chk_out("lu.wb_same", 1, 0, 0, 32'h0);
    next_cyc(); id_read(5'd5, 5'd0); id_rd_addr_i = 5'd6;
    #1 chk_out("lu.release", 0, 0, 0, 32'h0);

    // x0 load never tracked
    next_cyc(); id_load(5'd0);
    #1 chk_out("x0.issue", 0, 0, 0, 32'h0);
    next_cyc(); id_read(5'd0, 5'd0);
    #1 chk_out("x0.use0", 0, 0, 0, 32'h0);
    next_cyc(); id_read(5'd0, 5'd0);
    #1 chk_out("x0.use1", 0, 0, 0, 32'h0);

    // set and clear of x9 in the same cycle: set wins; hazard via rs2
    next_cyc(); id_load(5'd9); wb_load_we_i = 1; wb_rd_addr_i = 5'd9;
    #1 chk_out("sw.issue", 0, 0, 0, 32'h0);
    next_cyc(); id_read(5'd3, 5'd9);
    #1 chk_out("sw.use", 1, 0, 0, 32'h0);
    next_cyc(); id_read(5'd3, 5'd9); wb_load_we_i = 1; wb_rd_addr_i = 5'd9;
    #1 chk_out("sw.wb", 1, 0, 0, 32'h0);
    next_cyc(); id_read(5'd3, 5'd9);
    #1 chk_out("sw.release", 0, 0, 0, 32'h0);

    // jump: redirect one cycle, flush two cycles, second jump during flush ignored
    next_cyc(); ex_jump_i = 1; ex_jump_addr_i = 32'h0000_0100;
    #1 chk_out("jmp.t0", 0, 1, 1, 32'h0000_0100);
    next_cyc(); ex_jump_i = 1; ex_jump_addr_i = 32'h0000_0200;
    #1 chk_out("jmp.t1", 0, 1, 0, 32'h0);
    next_cyc();
    #1 chk_out("jmp.t2", 0, 0, 0, 32'h0);

    // divide: start at t, done at t+33
    next_cyc(); ex_div_start_i = 1;
    #1 chk_out("div.t0", 1, 0, 0, 32'h0);
    for (int i = 1; i <= 32; i++) begin
      next_cyc();
      #1 chk_out($sformatf("div.t%0d", i), 1, 0, 0, 32'h0);
    end
    next_cyc(); ex_div_done_i = 1;
    #1 chk_out("div.done", 0, 0, 0, 32'h0);
    next_cyc();
    #1 chk_out("div.after", 0, 0, 0, 32'h0);

    // single-cycle divide
    next_cyc(); ex_div_start_i = 1; ex_div_done_i = 1;
    #1 chk_out("div1.t0", 0, 0, 0, 32'h0);
    next_cyc();
    #1 chk_out("div1.t1", 0, 0, 0, 32'h0);

    // jump + load-use + div_start + load issue in one cycle
    next_cyc(); id_load(5'd3);
    #1 chk_out("mix.setup", 0, 0, 0, 32'h0);
    next_cyc(); id_load(5'd4); id_rs1_addr_i = 5'd3;
    ex_jump_i = 1; ex_jump_addr_i = 32'h0000_0044; ex_div_start_i = 1;
    #1 chk_out("mix.t0", 0, 1, 1, 32'h0000_0044);
    next_cyc(); id_read(5'd3, 5'd0);
    #1 chk_out("mix.t1", 0, 1, 0, 32'h0);
    next_cyc(); id_read(5'd4, 5'd0);
    #1 chk_out("mix.no_x4", 0, 0, 0, 32'h0);
    next_cyc(); id_read(5'd0, 5'd3);
    #1 chk_out("mix.x3_held", 1, 0, 0, 32'h0);

    // reset during a divide with x7 pending
    next_cyc(); id_load(5'd7);
    #1 chk_out("rst.setup", 0, 0, 0, 32'h0);
    next_cyc(); ex_div_start_i = 1;
    #1 chk_out("rst.div0", 1, 0, 0, 32'h0);
    next_cyc();
    #1 chk_out("rst.div1", 1, 0, 0, 32'h0);
    next_cyc(); rst = 1;
    #1 chk_out("rst.in", 0, 0, 0, 32'h0);
    next_cyc(); rst = 0; id_read(5'd7, 5'd3);
    #1 chk_out("rst.cleared", 0, 0, 0, 32'h0);
    next_cyc();
    #1 chk_out("rst.idle", 0, 0, 0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
